// File: rtl/toggle_interval_monitor.sv
// -----------------------------------------------------------------------------
// toggle_interval_monitor
//
// Watches a single-bit line (possibly asynchronous to clk), synchronizes it,
// detects rising and falling edges, and measures the gap in clock cycles
// between consecutive edges. Each measured gap is checked against the legal
// window [MIN_GAP, MAX_GAP]. Running min/max/edge/violation statistics are kept.
//
// Parameters
//   CNT_W    width of gap counter and interval/min/max outputs (>= 2)
//   MIN_GAP  smallest legal interval in clk cycles
//   MAX_GAP  largest legal interval in clk cycles (< 2^CNT_W - 1)
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset, clears all state
//   en             in   measurement enable
//   clear_stats    in   synchronous clear of min/max/edge/violation stats
//   d              in   monitored line
//   rise           out  one-cycle pulse per rising edge
//   fall           out  one-cycle pulse per falling edge
//   interval_valid out  one-cycle pulse, interval holds a new measurement
//   interval       out  cycles between the last two edges
//   overflow       out  with interval_valid: gap saturated
//   viol           out  with interval_valid: gap outside legal window
//   min_int        out  smallest interval since reset/clear
//   max_int        out  largest interval since reset/clear
//   edge_count     out  edges seen while enabled, saturating
//   viol_count     out  violating intervals, saturating
// -----------------------------------------------------------------------------
module toggle_interval_monitor #(
    parameter int CNT_W   = 8,
    parameter int MIN_GAP = 1,
    parameter int MAX_GAP = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear_stats,
    input  logic             d,
    output logic             rise,
    output logic             fall,
    output logic             interval_valid,
    output logic [CNT_W-1:0] interval,
    output logic             overflow,
    output logic             viol,
    output logic [CNT_W-1:0] min_int,
    output logic [CNT_W-1:0] max_int,
    output logic [15:0]      edge_count,
    output logic [7:0]       viol_count
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_GAP);
    localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_GAP);

    // Synchronizer chain; s3 is the history flop used for edge detection.
    logic s1_q, s2_q, s3_q;
    logic edge_s;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             rise_q, fall_q, valid_q, ovf_q, viol_q;
    logic [CNT_W-1:0] interval_q;

    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [15:0]      ecnt_q, ecnt_d;
    logic [7:0]       vcnt_q, vcnt_d;

    logic             cnt_sat_s;
    logic             cnt_out_of_window_s;

    assign edge_s              = s2_q ^ s3_q;
    assign cnt_sat_s           = (cnt_q == CNT_MAX);
    assign cnt_out_of_window_s = cnt_sat_s || (cnt_q < MIN_LIM) || (cnt_q > MAX_LIM);

    // Gap counter next state: reload on an edge, otherwise saturating count;
    // frozen while disabled so no stale value can leak into a report.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = cnt_q;
        end else if (edge_s) begin
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cnt_sat_s) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Statistics next state. They consume the registered pulses, so they lag
    // interval_valid by one cycle; a clear in that cycle discards the update.
    always_comb begin
        min_d  = min_q;
        max_d  = max_q;
        ecnt_d = ecnt_q;
        vcnt_d = vcnt_q;
        if (clear_stats) begin
            min_d  = CNT_MAX;
            max_d  = {CNT_W{1'b0}};
            ecnt_d = 16'd0;
            vcnt_d = 8'd0;
        end else if (en) begin
            if (valid_q) begin
                if (interval_q < min_q) begin
                    min_d = interval_q;
                end else begin
                    min_d = min_q;
                end
                if (interval_q > max_q) begin
                    max_d = interval_q;
                end else begin
                    max_d = max_q;
                end
                if (viol_q && (vcnt_q != 8'hFF)) begin
                    vcnt_d = vcnt_q + 8'd1;
                end else begin
                    vcnt_d = vcnt_q;
                end
            end else begin
                min_d  = min_q;
                max_d  = max_q;
                vcnt_d = vcnt_q;
            end
            if ((rise_q || fall_q) && (ecnt_q != 16'hFFFF)) begin
                ecnt_d = ecnt_q + 16'd1;
            end else begin
                ecnt_d = ecnt_q;
            end
        end else begin
            min_d  = min_q;
            max_d  = max_q;
            ecnt_d = ecnt_q;
            vcnt_d = vcnt_q;
        end
    end

    // Synchronizer, FSM, registered pulses/measurement and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            viol_q     <= 1'b0;
            interval_q <= {CNT_W{1'b0}};
            min_q      <= CNT_MAX;
            max_q      <= {CNT_W{1'b0}};
            ecnt_q     <= 16'd0;
            vcnt_q     <= 8'd0;
        end else begin
            s1_q    <= d;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            cnt_q   <= cnt_d;
            min_q   <= min_d;
            max_q   <= max_d;
            ecnt_q  <= ecnt_d;
            vcnt_q  <= vcnt_d;

            // Pulses default low and are only raised for one cycle below.
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            viol_q  <= 1'b0;

            if (en) begin
                if (edge_s) begin
                    rise_q <= s2_q;
                    fall_q <= ~s2_q;
                end
                case (state_q)
                    ST_IDLE: begin
                        // First edge only arms; cnt is reloaded by cnt_d.
                        if (edge_s) begin
                            state_q <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        if (edge_s) begin
                            valid_q    <= 1'b1;
                            interval_q <= cnt_q;
                            ovf_q      <= cnt_sat_s;
                            viol_q     <= cnt_out_of_window_s;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end else begin
                state_q <= ST_IDLE;
            end
        end
    end

    assign rise           = rise_q;
    assign fall           = fall_q;
    assign interval_valid = valid_q;
    assign interval       = interval_q;
    assign overflow       = ovf_q;
    assign viol           = viol_q;
    assign min_int        = min_q;
    assign max_int        = max_q;
    assign edge_count     = ecnt_q;
    assign viol_count     = vcnt_q;

endmodule
